// File: rtl/sound_mix_pkg.sv
// Shared constants and helpers for the DOC output mixer: the volume scale,
// the route-mute rule, signed saturation and the config address fields.
package sound_mix_pkg;

  localparam int unsigned CFG_W     = 8;
  localparam int unsigned VOL_UNITY = 128;
  localparam int unsigned VOL_SHIFT = 7;

  // cfg_addr MSB selects the table; the remaining bits are the channel address
  localparam logic CFG_SEL_ROUTE = 1'b0;
  localparam logic CFG_SEL_VOL   = 1'b1;

  function automatic logic route_muted(input logic [CFG_W-1:0] route,
                                       input int unsigned      num_out);
    return ({{(32-CFG_W){1'b0}}, route} >= num_out);
  endfunction

  // Clamp v into the signed range of a w-bit word (w <= 31)
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] v,
                                               input int unsigned        w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'd1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mix_fifo.sv
// Small frame FIFO with registered head (no fall-through); a push into a full
// FIFO succeeds only when a pop happens in the same cycle.
module mix_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sound_mixer_out.sv
// DOC output mixer: per-ca route/volume, per-frame accumulation with
// saturation, frame FIFO to the audio sink. Option: MIXER_PEAK_METER_EN.
module sound_mixer_out
  import sound_mix_pkg::*;
#(
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned CA_W       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         CLK_14M,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [CA_W-1:0]              in_ca,
  input  logic signed [SAMPLE_W-1:0]   in_sample,
  input  logic                         frame_tick,
  input  logic                         cfg_wr,
  input  logic [CA_W:0]                cfg_addr,
  input  logic [CFG_W-1:0]             cfg_data,
  output logic [CFG_W-1:0]             cfg_rdata,
  input  logic                         clr_status,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_OUT*SAMPLE_W-1:0]  out_data,
  output logic                         clip,
  output logic                         overflow
`ifdef MIXER_PEAK_METER_EN
  ,
  output logic [NUM_OUT*SAMPLE_W-1:0]  peak_out
`endif
);

  localparam int unsigned NUM_CA = 2 ** CA_W;
  localparam int unsigned TERM_W = SAMPLE_W + 2;
  localparam int unsigned WORD_W = NUM_OUT * SAMPLE_W;

  logic [CFG_W-1:0] route_q [NUM_CA];
  logic [CFG_W-1:0] vol_q   [NUM_CA];
  logic [CA_W-1:0]  cfg_ca;

  assign cfg_ca    = cfg_addr[CA_W-1:0];
  assign cfg_rdata = (cfg_addr[CA_W] == CFG_SEL_VOL) ? vol_q[cfg_ca] : route_q[cfg_ca];

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CA; i++) begin
        route_q[i] <= CFG_W'(i % NUM_OUT);
        vol_q[i]   <= CFG_W'(VOL_UNITY);
      end
    end else if (cfg_wr) begin
      if (cfg_addr[CA_W] == CFG_SEL_VOL) vol_q[cfg_ca]   <= cfg_data;
      else                               route_q[cfg_ca] <= cfg_data;
    end
  end

  // Stage 1: scale by volume and latch destination alongside the frame marker
  logic [CFG_W-1:0]                in_route;
  logic [CFG_W-1:0]                in_vol;
  logic signed [SAMPLE_W+CFG_W:0]  prod;
  logic signed [TERM_W-1:0]        term_in;

  assign in_route = route_q[in_ca];
  assign in_vol   = vol_q[in_ca];
  assign prod     = in_sample * $signed({1'b0, in_vol});
  assign term_in  = TERM_W'(prod >>> VOL_SHIFT);

  logic                     s1_valid;
  logic                     s1_tick;
  logic [CFG_W-1:0]         s1_dest;
  logic signed [TERM_W-1:0] s1_term;

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_tick  <= 1'b0;
      s1_dest  <= '0;
      s1_term  <= '0;
    end else begin
      s1_valid <= in_valid && !route_muted(in_route, NUM_OUT);
      s1_tick  <= frame_tick;
      s1_dest  <= in_route;
      s1_term  <= term_in;
    end
  end

  // Stage 2: accumulate; on the marker the same sum forms the frame word
  logic signed [ACC_W-1:0] acc_q    [NUM_OUT];
  logic signed [31:0]      sum_w    [NUM_OUT];
  logic signed [31:0]      acc_sat  [NUM_OUT];
  logic signed [31:0]      word_sat [NUM_OUT];
  logic [WORD_W-1:0]       frame_word;
  logic                    acc_clip;
  logic                    word_clip;

  always_comb begin
    acc_clip   = 1'b0;
    word_clip  = 1'b0;
    frame_word = '0;
    for (int unsigned c = 0; c < NUM_OUT; c++) begin
      sum_w[c]    = 32'(acc_q[c]) +
                    ((s1_valid && (s1_dest == CFG_W'(c))) ? 32'(s1_term) : 32'sd0);
      acc_sat[c]  = sat_w(sum_w[c], ACC_W);
      word_sat[c] = sat_w(acc_sat[c], SAMPLE_W);
      acc_clip    = acc_clip | (acc_sat[c] != sum_w[c]);
      word_clip   = word_clip | (s1_tick && (word_sat[c] != acc_sat[c]));
      frame_word[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(word_sat[c]);
    end
  end

  logic              push_q;
  logic [WORD_W-1:0] word_q;
  logic              clip_q;
  logic              overflow_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NUM_OUT; c++) acc_q[c] <= '0;
      push_q <= 1'b0;
      word_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_OUT; c++)
        acc_q[c] <= s1_tick ? '0 : ACC_W'(acc_sat[c]);
      push_q <= s1_tick;
      if (s1_tick) word_q <= frame_word;
    end
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      clip_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      clip_q     <= acc_clip || word_clip || (clip_q && !clr_status);
      overflow_q <= (push_q && fifo_full && !pop) || (overflow_q && !clr_status);
    end
  end

  assign clip     = clip_q;
  assign overflow = overflow_q;

  mix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (CLK_14M),
    .rst_n (reset_n),
    .push  (push_q),
    .din   (word_q),
    .full  (fifo_full),
    .pop   (pop),
    .empty (fifo_empty),
    .head  (out_data)
  );

`ifdef MIXER_PEAK_METER_EN
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] S_MAX = ~S_MIN;

  logic [SAMPLE_W-1:0] peak_q [NUM_OUT];
  logic [SAMPLE_W-1:0] mag    [NUM_OUT];

  // Magnitude of the word being pushed; the most negative value clamps to max
  always_comb begin
    for (int unsigned c = 0; c < NUM_OUT; c++) begin
      if (word_q[c*SAMPLE_W +: SAMPLE_W] == S_MIN) mag[c] = S_MAX;
      else if (word_q[c*SAMPLE_W + SAMPLE_W - 1])  mag[c] = -word_q[c*SAMPLE_W +: SAMPLE_W];
      else                                         mag[c] = word_q[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NUM_OUT; c++) peak_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_OUT; c++) begin
        if (push_q && (clr_status || (mag[c] > peak_q[c]))) peak_q[c] <= mag[c];
        else if (clr_status)                                peak_q[c] <= '0;
      end
    end
  end

  always_comb begin
    peak_out = '0;
    for (int unsigned c = 0; c < NUM_OUT; c++) peak_out[c*SAMPLE_W +: SAMPLE_W] = peak_q[c];
  end
`endif

endmodule
